// File: rtl/truth_table_sweeper.sv
// Stimulus/capture engine: sweeps every input vector of an N_IN-input function,
// captures its truth table and flags disagreement with an expected table. Optional error stats via SWEEP_ERRCNT_EN.
module truth_table_sweeper #(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_table,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 mismatch
`ifdef SWEEP_ERRCNT_EN
    ,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_fail
`endif
);

    localparam int              TBL_W       = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cnt;
    logic [N_IN-1:0]    r_vec;
    logic [TBL_W-1:0]   r_table;
    logic               r_mismatch;
    logic               r_done;
    logic               w_start;
    logic               w_bad;

    assign w_start = (r_state == S_IDLE) && start;
    assign w_bad   = (r_state == S_SAMPLE) && (f_in != exp_table[r_vec]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == SETTLE_LAST) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_vec == LAST_VEC) ? S_DONE : S_SETTLE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_vec      <= '0;
            r_table    <= '0;
            r_mismatch <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt      <= '0;
                        r_vec      <= '0;
                        r_table    <= '0;
                        r_mismatch <= 1'b0;
                    end
                end
                S_SETTLE: r_cnt <= r_cnt + 8'd1;
                S_SAMPLE: begin
                    r_table[r_vec] <= f_in;
                    r_mismatch     <= r_mismatch | w_bad;
                    if (r_vec == LAST_VEC) begin
                        // done is registered here so it is high exactly while in DONE
                        r_done <= 1'b1;
                    end else begin
                        r_vec <= r_vec + 1'b1;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SWEEP_ERRCNT_EN
    localparam logic [N_IN:0] ERR_MAX = (N_IN+1)'(TBL_W);

    logic [N_IN:0]   r_err_cnt;
    logic [N_IN-1:0] r_first_fail;

    // r_mismatch is still clear on the first failing sample of a sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_first_fail <= '0;
        end else if (w_start) begin
            r_err_cnt    <= '0;
            r_first_fail <= '0;
        end else if (w_bad) begin
            if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 1'b1;
            if (!r_mismatch)          r_first_fail <= r_vec;
        end
    end

    assign err_cnt    = r_err_cnt;
    assign first_fail = r_first_fail;
`endif

    assign busy      = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done      = r_done;
    assign vec_out   = r_vec;
    assign table_out = r_table;
    assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default instance (SETTLE_CYC=2) and a SETTLE_CYC=1 instance.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        start0, start1;
    logic [15:0] exp0, exp1, model0;
    logic        f_in0, f_in1;
    logic [3:0]  vec0, vec1;
    logic        busy0, busy1, done0, done1, mis0, mis1;
    logic [15:0] tbl0, tbl1;
`ifdef SWEEP_ERRCNT_EN
    logic [4:0]  err_cnt0, err_cnt1;
    logic [3:0]  ff0, ff1;
`endif

    always #5 clk = ~clk;

    assign f_in0 = model0[vec0];
    assign f_in1 = 1'b0;

    truth_table_sweeper u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_table(exp0), .f_in(f_in0),
        .vec_out(vec0), .busy(busy0), .done(done0), .table_out(tbl0), .mismatch(mis0)
`ifdef SWEEP_ERRCNT_EN
        , .err_cnt(err_cnt0), .first_fail(ff0)
`endif
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_table(exp1), .f_in(f_in1),
        .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tbl1), .mismatch(mis1)
`ifdef SWEEP_ERRCNT_EN
        , .err_cnt(err_cnt1), .first_fail(ff1)
`endif
    );

    // Pulse start on dut0, then observe 70 cycles; k=0 is the first negedge after the accepting edge.
    task automatic sweep0(input int pulse_a, input int pulse_b,
                          output int n_busy, output int n_done, output int done_at, output int n_vec_err);
        n_busy = 0; n_done = 0; done_at = -1; n_vec_err = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        for (int k = 0; k < 70; k++) begin
            start0 = (k == pulse_a || k == pulse_b);
            if (busy0) begin
                n_busy++;
                if (vec0 !== 4'(k / 3)) n_vec_err++;
            end
            if (done0) begin
                n_done++;
                done_at = k;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (vec0 !== 4'h0)      begin errors++; $display("FAIL reset_vec got %h exp 0", vec0); end
        checks++; if (busy0 !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
        checks++; if (done0 !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
        checks++; if (tbl0 !== 16'h0)     begin errors++; $display("FAIL reset_table got %h exp 0", tbl0); end
        checks++; if (mis0 !== 1'b0)      begin errors++; $display("FAIL reset_mismatch got %b exp 0", mis0); end
        start0 = 1'b0; start1 = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %b/%b exp 0/0", busy0, busy1); end
        checks++; if (vec0 !== 4'h0)      begin errors++; $display("FAIL idle_after_reset_vec got %h exp 0", vec0); end
    endtask

    task automatic test_full_sweep;
        int nb, nd, da, ve;
        exp0 = 16'hA5A5; model0 = 16'hA5A5;
        sweep0(-1, -1, nb, nd, da, ve);
        checks++; if (nb !== 48)          begin errors++; $display("FAIL full_busy_cycles got %0d exp 48", nb); end
        checks++; if (nd !== 1)           begin errors++; $display("FAIL full_done_pulses got %0d exp 1", nd); end
        checks++; if (da !== 48)          begin errors++; $display("FAIL full_done_cycle got %0d exp 48", da); end
        checks++; if (ve !== 0)           begin errors++; $display("FAIL full_vec_steps bad=%0d exp 0", ve); end
        checks++; if (tbl0 !== 16'hA5A5)  begin errors++; $display("FAIL full_table got %h exp a5a5", tbl0); end
        checks++; if (mis0 !== 1'b0)      begin errors++; $display("FAIL full_mismatch got %b exp 0", mis0); end
        checks++; if (vec0 !== 4'hF)      begin errors++; $display("FAIL full_vec_hold got %h exp f", vec0); end
    endtask

    task automatic test_fault;
        int nb, nd, da, ve;
        exp0 = 16'hA5A5; model0 = 16'hA5A5 ^ 16'h0020;
        sweep0(-1, -1, nb, nd, da, ve);
        checks++; if (tbl0 !== 16'hA585)  begin errors++; $display("FAIL fault_table got %h exp a585", tbl0); end
        checks++; if (mis0 !== 1'b1)      begin errors++; $display("FAIL fault_mismatch got %b exp 1", mis0); end
        checks++; if (nb !== 48)          begin errors++; $display("FAIL fault_busy_cycles got %0d exp 48", nb); end
`ifdef SWEEP_ERRCNT_EN
        checks++; if (err_cnt0 !== 5'd1)  begin errors++; $display("FAIL fault_err_cnt got %0d exp 1", err_cnt0); end
        checks++; if (ff0 !== 4'd5)       begin errors++; $display("FAIL fault_first_fail got %0d exp 5", ff0); end
`endif
    endtask

    task automatic test_ignored_start;
        int nb, nd, da, ve;
        exp0 = 16'h3C96; model0 = 16'h3C96;
        sweep0(10, 30, nb, nd, da, ve);
        checks++; if (nb !== 48)          begin errors++; $display("FAIL ign_busy_cycles got %0d exp 48", nb); end
        checks++; if (nd !== 1)           begin errors++; $display("FAIL ign_done_pulses got %0d exp 1", nd); end
        checks++; if (tbl0 !== 16'h3C96)  begin errors++; $display("FAIL ign_table got %h exp 3c96", tbl0); end
        checks++; if (mis0 !== 1'b0)      begin errors++; $display("FAIL ign_mismatch_cleared got %b exp 0", mis0); end
    endtask

    task automatic test_reset_mid_sweep;
        int nb, nd, da, ve;
        exp0 = 16'hFFFF; model0 = 16'h0F0F;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (busy0 !== 1'b1 || vec0 !== 4'd6) begin errors++; $display("FAIL mid_pre_reset busy %b vec %h exp 1/6", busy0, vec0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b0)     begin errors++; $display("FAIL async_busy got %b exp 0", busy0); end
        checks++; if (vec0 !== 4'h0)      begin errors++; $display("FAIL async_vec got %h exp 0", vec0); end
        checks++; if (tbl0 !== 16'h0)     begin errors++; $display("FAIL async_table got %h exp 0", tbl0); end
        checks++; if (mis0 !== 1'b0)      begin errors++; $display("FAIL async_mismatch got %b exp 0", mis0); end
        @(negedge clk) rst_n = 1'b1;
        exp0 = 16'h1234; model0 = 16'h1234;
        sweep0(-1, -1, nb, nd, da, ve);
        checks++; if (nb !== 48 || nd !== 1) begin errors++; $display("FAIL restart_timing busy %0d done %0d exp 48/1", nb, nd); end
        checks++; if (ve !== 0)           begin errors++; $display("FAIL restart_vec_steps bad=%0d exp 0", ve); end
        checks++; if (tbl0 !== 16'h1234)  begin errors++; $display("FAIL restart_table got %h exp 1234", tbl0); end
    endtask

    task automatic test_settle_one;
        int nb = 0, nd = 0, da = -1, ve = 0;
        exp1 = 16'hFFFF;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (busy1) begin
                nb++;
                if (vec1 !== 4'(k / 2)) ve++;
            end
            if (done1) begin nd++; da = k; end
            @(negedge clk);
        end
        checks++; if (nb !== 32)          begin errors++; $display("FAIL s1_busy_cycles got %0d exp 32", nb); end
        checks++; if (nd !== 1 || da !== 32) begin errors++; $display("FAIL s1_done pulses %0d at %0d exp 1 at 32", nd, da); end
        checks++; if (ve !== 0)           begin errors++; $display("FAIL s1_vec_steps bad=%0d exp 0", ve); end
        checks++; if (tbl1 !== 16'h0)     begin errors++; $display("FAIL s1_table got %h exp 0", tbl1); end
        checks++; if (mis1 !== 1'b1)      begin errors++; $display("FAIL s1_mismatch got %b exp 1", mis1); end
`ifdef SWEEP_ERRCNT_EN
        checks++; if (err_cnt1 !== 5'd16) begin errors++; $display("FAIL s1_err_cnt got %0d exp 16", err_cnt1); end
        checks++; if (ff1 !== 4'd0)       begin errors++; $display("FAIL s1_first_fail got %0d exp 0", ff1); end
`endif
    endtask

    initial begin
        start0 = 1'b0; start1 = 1'b0;
        exp0 = '0; exp1 = '0; model0 = '0;
        test_reset();
        test_full_sweep();
        test_fault();
        test_ignored_start();
        test_reset_mid_sweep();
        test_settle_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
